// File: rtl/shift_mix_add.sv
// Iterative AES round back-end: ShiftRows on capture, then one column per cycle
// through a single shared MixColumns unit (bypassed in the final round) and AddRoundKey.
module shift_mix_add (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_state_reg;
    logic [127:0] r_key;
    logic         r_last;
    logic [1:0]   r_col;

    logic [31:0]  w_col;
    logic [31:0]  w_key_col;
    logic [31:0]  w_mixed;
    logic [31:0]  w_new_col;
    logic         w_accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] o0, o1, o2, o3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        // 3a = xtime(a) ^ a
        o0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        o1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        o2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        o3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {o0, o1, o2, o3};
    endfunction

    // Byte b(4c+r) sits at bits [127-8(4c+r) -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign data_out  = r_state_reg;
    assign w_accept  = in_valid && (r_fsm == S_IDLE);

    always_comb begin
        w_col     = r_state_reg[127:96];
        w_key_col = r_key[127:96];
        case (r_col)
            2'd0: begin w_col = r_state_reg[127:96]; w_key_col = r_key[127:96]; end
            2'd1: begin w_col = r_state_reg[95:64];  w_key_col = r_key[95:64];  end
            2'd2: begin w_col = r_state_reg[63:32];  w_key_col = r_key[63:32];  end
            default: begin w_col = r_state_reg[31:0]; w_key_col = r_key[31:0]; end
        endcase
    end

    assign w_mixed   = r_last ? w_col : mix_column(w_col);
    assign w_new_col = w_mixed ^ w_key_col;

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (in_valid)     w_fsm_nxt = S_BUSY;
            S_BUSY:  if (r_col == 2'd3) w_fsm_nxt = S_DONE;
            S_DONE:  if (out_ready)    w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_reg <= '0;
            r_key       <= '0;
            r_last      <= 1'b0;
            r_col       <= 2'd0;
        end else if (w_accept) begin
            r_state_reg <= shift_rows(data_in);
            r_key       <= round_key;
            r_last      <= last_round;
            r_col       <= 2'd0;
        end else if (r_fsm == S_BUSY) begin
            case (r_col)
                2'd0:    r_state_reg[127:96] <= w_new_col;
                2'd1:    r_state_reg[95:64]  <= w_new_col;
                2'd2:    r_state_reg[63:32]  <= w_new_col;
                default: r_state_reg[31:0]   <= w_new_col;
            endcase
            r_col <= r_col + 2'd1;
        end
    end

endmodule

// File: tb/tb_shift_mix_add.sv
// Directed bench for shift_mix_add with an output scoreboard fed at accept time.
module tb_shift_mix_add;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] round_key;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [127:0] q[$];

    shift_mix_add dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .round_key(round_key), .last_round(last_round),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input logic l);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] m [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = d[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = s[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            m[4*c+0] = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
            m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
            m[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = (l ? t[i] : m[i]) ^ k[127-8*i -: 8];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: compare on every output handshake
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_output: got %h expected none", data_out);
            end else begin
                check("data_out", data_out, q.pop_front());
            end
        end
    end

    // Present a vector and wait (bounded) for the accept edge; returns #1 after it.
    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic l,
                        input logic [127:0] exp);
        bit ok;
        data_in = d; round_key = k; last_round = l; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 1'b0, 1'b1);
        q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("drain_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [127:0] d, k, hold;
        int t0, t1;
        bit ok;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        data_in = '0; round_key = '0; last_round = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_data_out", data_out, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1'b1);

        // FIPS-197 round 1 with latency check
        send(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
             1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            check("lat_early_valid", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        check("lat_e4_valid", out_valid, 1'b1);
        drain();

        // Final round bypass
        send(128'hd42711aee0bf98f1b8b45de51e415230, 128'h0, 1'b1,
             128'hd4bf5d30e0b452aeb84111f11e2798e5);
        drain();

        // Column mixer on identical columns
        send({4{32'hdb135345}}, 128'h0, 1'b0, {4{32'h8e4da1bc}});
        drain();

        // Random vectors against the model
        for (int n = 0; n < 4; n++) begin
            d = rnd128(); k = rnd128();
            send(d, k, n[0], model(d, k, n[0]));
            drain();
        end

        // Backpressure
        out_ready = 1'b0;
        d = rnd128(); k = rnd128();
        send(d, k, 1'b0, model(d, k, 1'b0));
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check("bp_valid_timeout", 1'b0, 1'b1);
        hold = data_out;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            data_in = rnd128();
            round_key = rnd128();
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_data_hold", data_out, hold);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after", in_ready, 1'b1);
        drain();

        // Reset mid-operation
        d = rnd128(); k = rnd128();
        send(d, k, 1'b0, model(d, k, 1'b0));
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", data_out, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_data2", data_out, 128'h0);
        send(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
             1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049);
        drain();

        // Back-to-back with in_valid held high
        d = rnd128(); k = rnd128();
        data_in = d; round_key = k; last_round = 1'b0; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("b2b_first_timeout", 1'b0, 1'b1);
        q.push_back(model(d, k, 1'b0));
        @(posedge clk); #1;
        t0 = cyc;
        d = rnd128(); k = rnd128();
        data_in = d; round_key = k; last_round = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("b2b_second_timeout", 1'b0, 1'b1);
        q.push_back(model(d, k, 1'b1));
        @(posedge clk); #1;
        t1 = cyc;
        in_valid = 1'b0;
        check("b2b_period", t1 - t0, 6);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_mix_add.md
# shift_mix_add

Iterative AES round back-end placed directly downstream of the SubBytes stage. Takes the 128-bit substituted state plus the round key, then applies ShiftRows, MixColumns (one column per cycle through a single shared column mixer) and AddRoundKey. It supports a final-round mode that skips MixColumns. The result goes back to the round register or out as ciphertext, under a valid/ready handshake on both sides.

## Interface
- No parameters. Widths are fixed by AES-128.
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  data_in/round_key/last_round valid
- in_ready  out  1  block can accept; high only in IDLE
- data_in  in  128  SubBytes output state
- round_key  in  128  round key for AddRoundKey
- last_round  in  1  1 = final round; MixColumns bypassed
- out_valid  out  1  data_out valid; held until accepted
- out_ready  in  1  downstream accepts data_out
- data_out  out  128  ShiftRows → MixColumns (unless last_round) → XOR round_key

## Operation
- **Byte order.** Byte b_i, i=0..15, is data[127-8i -: 8]; b0 is the MSB byte.
- **State layout.** State element s[r][c] = b_(4c+r), so column c is bytes 4c..4c+3.
- **ShiftRows.** Combinational on capture: s'[r][c] = s[r][(c+r) mod 4].
- **MixColumns.** GF(2^8) multiply with polynomial 0x11B. xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00). Each output column is:
  - o0 = 2a0^3a1^a2^a3
  - o1 = a0^2a1^3a2^a3
  - o2 = a0^a1^2a2^3a3
  - o3 = 3a0^a1^a2^2a3
- **Datapath instances.** Exactly one column-mixer instance is shared across cycles. Column select is driven by a 2-bit counter col.
- **Registers.** state_reg (128), key_reg (128), last_reg (1), col (2), FSM.
- **FSM states:**
  - IDLE: in_ready=1. On in_valid: state_reg ← ShiftRows(data_in), key_reg ← round_key, last_reg ← last_round, col ← 0, go to BUSY.
  - BUSY: each cycle, column col of state_reg ← (last_reg ? column : MixColumn(column)) ^ key_reg column col; col ← col+1. When col==3, that write completes and the FSM goes to DONE.
  - DONE: out_valid=1, data_out=state_reg. On out_ready, go to IDLE.
- **Wrap-around.** col wraps from 3 to 0 naturally and is not used outside BUSY.
- **Input stability.** data_in/round_key changes while not in IDLE are ignored, because inputs are captured only on the accept edge.
- **No overlap.** in_ready is 0 in DONE, so a new input cannot be accepted in the same cycle as an output handshake. The next accept is possible at the earliest one cycle after leaving DONE.
- **Reset.** rst at any time, including mid-BUSY, forces:
  - FSM=IDLE, col=0
  - state_reg, key_reg, last_reg = 0
  - out_valid=0, data_out=0, in_ready=1 once rst deasserts
  
  A partial result is discarded.

## Timing
- in_ready and out_valid are decoded from FSM registers only, with no combinational path from in_valid or out_ready.
- **Latency.**
  - Accept at edge E0 (in_valid & in_ready).
  - Columns 0..3 are written at E1..E4.
  - out_valid is high from after E4 until the edge where out_ready=1.
  - Minimum accept-to-accept period is 6 cycles.
- data_out is constant while out_valid=1 and changes only after handshake or reset.
- out_ready stalls hold DONE indefinitely with no data change.

## Test plan
- **FIPS-197 App. B round 1.**
  - Stimulus: data_in=d42711aee0bf98f1b8b45de51e415230, round_key=a0fafe1788542cb123a339392a6c7605, last_round=0, out_ready=1.
  - Required: data_out=a49c7ff2689f352b6b5bea43026a5049, with out_valid high exactly at the 4th edge after accept.
- **Final round (bypass).**
  - Stimulus: data_in=d42711aee0bf98f1b8b45de51e415230, round_key=0, last_round=1.
  - Required: data_out=d4bf5d30e0b452aeb84111f11e2798e5 (ShiftRows only).
- **Single-column mixer.**
  - Stimulus: data_in=db135345 in column 0 with zero rows chosen so ShiftRows is neutral (all four columns = db135345), key=0, last_round=0.
  - Required: data_out=8e4da1bc repeated in every column.
- **Backpressure.**
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises, and toggle data_in/in_valid meanwhile.
  - Required: in_ready=0, data_out unchanged. Handshake on out_ready=1, then in_ready=1 the next cycle.
- **Reset mid-operation.**
  - Stimulus: assert rst two cycles after accept.
  - Required: out_valid=0, data_out=0, in_ready=1 after release. A following vector produces the correct result with no residue.
- **Back-to-back.**
  - Stimulus: in_valid held high with two vectors and out_ready=1.
  - Required: second accept occurs 6 cycles after the first, and both results are correct and in order.
